smvm_stream_tx: RTL and testbench
=================================

Name: smvm_stream_tx

Overview:
- Host-side transmitter for the SMVM serial input stream. It accepts one frame from the host (header, dense vector, sparse entries) over a ready/valid port and buffers it completely.
- It then emits the frame cycle-by-cycle on the (tx_val, tx_ipv, tx_valid) stream that drives the SMVM val_in/ipv_in/in_valid inputs.
- Full buffering is mandatory: the stream has no backpressure, and a mid-frame tx_valid drop ends the matrix phase.

Parameters:
- K, 4, entries per ALU group; nnz is padded to a multiple of K.
- MAX_COLS, 256, vector buffer depth; also the upper limit for cols.
- MAX_NNZ, 64, entry buffer depth; must be a multiple of K.
- GAP_CYCLES, 8, minimum idle cycles after a frame, covering downstream CAL and RST.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  host word valid.
- s_ready  out  1  block accepts a word; a transfer occurs when s_valid and s_ready are both 1.
- s_kind  in  2  word type: 0 HDR, 1 VEC, 2 ENT, 3 END.
- s_data  in  18  payload.
  - HDR: [17:9] rows, [8:0] cols.
  - VEC: [7:0] vector value.
  - ENT: [7:0] value, [16:8] column, [17] last-in-row.
  - END: payload ignored.
- tx_val  out  8  stream byte.
- tx_ipv  out  1  stream side bit.
- tx_valid  out  1  stream valid.
- busy  out  1  high from END acceptance until GAP ends.
- err  out  1  sticky protocol error; cleared by an accepted HDR.
- frame_done  out  1  one-cycle pulse on the last cycle of GAP.

Behaviour:
- Reset values:
  - State LOAD; s_ready=1.
  - tx_val=0, tx_ipv=0, tx_valid=0.
  - busy=0, err=0, frame_done=0.
  - All counters 0; header_seen=0.
- All outputs are registered.
- 9-bit fields are sent as {tx_val, tx_ipv}: tx_val carries bits [8:1] and tx_ipv carries bit 0.
- LOAD (s_ready=1):
  - HDR stores rows/cols, clears vec_cnt, nnz and err, and sets header_seen.
  - VEC writes vec[vec_cnt] and increments vec_cnt.
  - ENT writes entry[nnz] and increments nnz.
  - END with header_seen goes to TX_ROWS on the next cycle; s_ready drops the cycle after END is accepted.
- Error handling in LOAD (each sets err):
  - VEC or ENT before HDR: word dropped.
  - VEC when vec_cnt==cols: word dropped.
  - ENT when nnz==MAX_NNZ: word dropped.
  - HDR with rows==0, cols==0 or cols>MAX_COLS: header_seen cleared, so a later END is ignored (err only) and the state stays LOAD.
  - END with vec_cnt<cols: missing vector slots are transmitted as 0 and err is set.
- TX_ROWS: emits rows for 1 cycle.
- TX_COLS: emits cols for 1 cycle.
- TX_VEC: emits vec[0..cols-1], tx_ipv=0, for cols cycles.
- TX_VAL / TX_IDX: for each entry e in 0..P-1, where P = ceil(nnz/K)*K:
  - TX_VAL cycle: tx_val=value, tx_ipv=last-in-row.
  - TX_IDX cycle: {tx_val, tx_ipv}=column.
  - Entries with e>=nnz are padding: value 0, column 0, last 0.
  - If nnz==0, the matrix phase is skipped.
- tx_valid=1 for exactly 2+cols+2P consecutive cycles. The first tx_valid cycle is 2 cycles after the END handshake.
- GAP: tx_valid=0 for GAP_CYCLES cycles. frame_done pulses on the final GAP cycle, then the block returns to LOAD with s_ready=1. Buffer contents are kept but the counters reset.
- s_valid while s_ready=0 is ignored; the host holds the word.
- rst mid-frame: immediate return to reset values. tx_valid drops asynchronously; the downstream sees an aborted frame.

Optional Feature:
- Macro STREAM_TX_COLCHK_EN.
- Defined: an ENT with column>=cols sets err. The entry is still stored and transmitted unchanged.
- Undefined: no column range check. err sources are limited to those listed in Behaviour.

Decomposition:
- Package smvm_stream_pkg holds:
  - kind encodings: KIND_HDR, KIND_VEC, KIND_ENT, KIND_END;
  - the state enum: LOAD, TX_ROWS, TX_COLS, TX_VEC, TX_VAL, TX_IDX, GAP;
  - widths: DIM_W=9, VAL_W=8;
  - the ENT payload field offsets.
- Sub-module smvm_frame_buffer:
  - vector and entry memories;
  - write ports driven from LOAD, read ports addressed by the TX counters;
  - reads of padding addresses return zeros.
- The top level keeps the FSM, counters, error logic and output registers.

Test Plan:
- Basic frame: HDR rows=2 cols=3; VEC 5,6,7; ENT (3,c0,0), (4,c2,1), (9,c1,1); END. Expected tx pairs (tx_val, tx_ipv), 13 tx_valid cycles, then 8 idle cycles, then frame_done:
  - (1,0), (1,1);
  - (5,0), (6,0), (7,0);
  - (3,0), (0,0), (4,1), (1,0), (9,1), (0,1);
  - pad (0,0), (0,0).
- nnz=0: HDR rows=1 cols=2; VEC 10,20; END -> 4 tx cycles (0,1), (1,0), (10,0), (20,0); then GAP.
- Overflow: 65 ENT words with MAX_NNZ=64 -> err=1 after the 65th word; transmission carries 64 entries (128 matrix cycles, no padding).
- Short vector: cols=4 with only 2 VEC words (8,9) then END -> vector phase (8,0), (9,0), (0,0), (0,0); err=1.
- Bad header and recovery: HDR cols=0 then END -> no tx_valid, err=1, s_ready stays 1. A valid HDR then clears err.
- Reset mid-frame: assert rst during TX_VEC -> tx_valid=0 and s_ready=1 immediately, err=0. A new frame then transmits correctly.
- With STREAM_TX_COLCHK_EN: cols=3, ENT column 5 -> err=1, and the index cycle is still (2,1).

Source files
------------

// File: rtl/smvm_stream_pkg.sv
// Shared types and constants for the SMVM stream transmitter.
// Word kinds, FSM states, field widths and payload offsets.
package smvm_stream_pkg;

  localparam int DIM_W  = 9;
  localparam int VAL_W  = 8;
  localparam int WORD_W = 18;

  localparam logic [1:0] KIND_HDR = 2'd0;
  localparam logic [1:0] KIND_VEC = 2'd1;
  localparam logic [1:0] KIND_ENT = 2'd2;
  localparam logic [1:0] KIND_END = 2'd3;

  localparam int HDR_COLS_LSB = 0;
  localparam int HDR_ROWS_LSB = 9;

  localparam int ENT_VAL_LSB  = 0;
  localparam int ENT_COL_LSB  = 8;
  localparam int ENT_LAST_BIT = 17;

  typedef enum logic [2:0] {
    LOAD,
    TX_ROWS,
    TX_COLS,
    TX_VEC,
    TX_VAL,
    TX_IDX,
    GAP
  } state_t;

  typedef struct packed {
    logic             last;
    logic [DIM_W-1:0] col;
    logic [VAL_W-1:0] val;
  } ent_t;

  function automatic ent_t unpack_ent(
    input logic [WORD_W-1:0] w
  );
    ent_t e;
    e.val  = w[ENT_VAL_LSB +: VAL_W];
    e.col  = w[ENT_COL_LSB +: DIM_W];
    e.last = w[ENT_LAST_BIT];
    return e;
  endfunction

endpackage

// File: rtl/smvm_stream_tx_buffer.sv
// Frame buffer for the SMVM stream transmitter (smvm_frame_buffer).
// Vector and entry memories; reads past the filled length return zero.
module smvm_frame_buffer
  import smvm_stream_pkg::*;
#(
  parameter int MAX_COLS = 256,
  parameter int MAX_NNZ  = 64,
  parameter int VAW      = $clog2(MAX_COLS),
  parameter int EAW      = $clog2(MAX_NNZ),
  parameter int NW       = EAW + 1
) (
  input  logic             clk,
  input  logic             vec_we,
  input  logic [VAW-1:0]   vec_waddr,
  input  logic [VAL_W-1:0] vec_wdata,
  input  logic [DIM_W-1:0] vec_raddr,
  input  logic [DIM_W-1:0] vec_len,
  output logic [VAL_W-1:0] vec_rdata,
  input  logic             ent_we,
  input  logic [EAW-1:0]   ent_waddr,
  input  ent_t             ent_wdata,
  input  logic [NW-1:0]    ent_raddr,
  input  logic [NW-1:0]    ent_len,
  output ent_t             ent_rdata
);

  logic [VAL_W-1:0] vec_mem [MAX_COLS];
  ent_t             ent_mem [MAX_NNZ];

  // Host-side writes during LOAD.
  always_ff @(posedge clk) begin
    if (vec_we) vec_mem[vec_waddr] <= vec_wdata;
    if (ent_we) ent_mem[ent_waddr] <= ent_wdata;
  end

  // Slots never written this frame read as zero padding.
  always_comb begin
    vec_rdata = '0;
    ent_rdata = '0;
    if (vec_raddr < vec_len)
      vec_rdata = vec_mem[vec_raddr[VAW-1:0]];
    if (ent_raddr < ent_len)
      ent_rdata = ent_mem[ent_raddr[EAW-1:0]];
  end

endmodule

// File: rtl/smvm_stream_tx.sv
// SMVM stream transmitter: buffers one host frame, then streams it.
// Optional macro STREAM_TX_COLCHK_EN flags ENT columns >= cols.
module smvm_stream_tx
  import smvm_stream_pkg::*;
#(
  parameter int K          = 4,
  parameter int MAX_COLS   = 256,
  parameter int MAX_NNZ    = 64,
  parameter int GAP_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [1:0]        s_kind,
  input  logic [WORD_W-1:0] s_data,
  output logic [VAL_W-1:0]  tx_val,
  output logic              tx_ipv,
  output logic              tx_valid,
  output logic              busy,
  output logic              err,
  output logic              frame_done
);

  localparam int VAW = $clog2(MAX_COLS);
  localparam int EAW = $clog2(MAX_NNZ);
  localparam int NW  = EAW + 1;
  localparam int GW  = $clog2(GAP_CYCLES + 1);

  localparam logic [DIM_W-1:0] MAX_COLS_V = DIM_W'(MAX_COLS);
  localparam logic [NW-1:0]    MAX_NNZ_V  = NW'(MAX_NNZ);
  localparam logic [GW-1:0]    GAP_LAST   = GW'(GAP_CYCLES - 1);

  state_t           state, state_d;
  logic [DIM_W-1:0] rows, rows_d;
  logic [DIM_W-1:0] cols, cols_d;
  logic [DIM_W-1:0] vec_cnt, vec_cnt_d;
  logic [NW-1:0]    nnz, nnz_d;
  logic             hdr_seen, hdr_seen_d;
  logic [DIM_W-1:0] vcnt, vcnt_d;
  logic [NW-1:0]    ecnt, ecnt_d;
  logic [GW-1:0]    gcnt, gcnt_d;
  logic             err_d, busy_d, s_ready_d;
  logic             frame_done_d, tx_valid_d, tx_ipv_d;
  logic [VAL_W-1:0] tx_val_d;

  logic             hs;
  logic [DIM_W-1:0] hdr_rows, hdr_cols;
  logic             hdr_bad;
  ent_t             ent_in;
  logic             vec_we, ent_we;
  logic [VAL_W-1:0] vec_rdata;
  ent_t             ent_rdata;
  logic [NW-1:0]    pad_nnz;

  assign hs       = s_valid && s_ready;
  assign hdr_rows = s_data[HDR_ROWS_LSB +: DIM_W];
  assign hdr_cols = s_data[HDR_COLS_LSB +: DIM_W];
  assign hdr_bad  = (hdr_rows == '0) || (hdr_cols == '0) ||
                    (hdr_cols > MAX_COLS_V);
  assign ent_in   = unpack_ent(s_data);
  assign pad_nnz  = NW'((int'(nnz) + K - 1) / K * K);

  smvm_frame_buffer #(
    .MAX_COLS (MAX_COLS),
    .MAX_NNZ  (MAX_NNZ)
  ) u_buf (
    .clk       (clk),
    .vec_we    (vec_we),
    .vec_waddr (vec_cnt[VAW-1:0]),
    .vec_wdata (s_data[VAL_W-1:0]),
    .vec_raddr (vcnt),
    .vec_len   (vec_cnt),
    .vec_rdata (vec_rdata),
    .ent_we    (ent_we),
    .ent_waddr (nnz[EAW-1:0]),
    .ent_wdata (ent_in),
    .ent_raddr (ecnt),
    .ent_len   (nnz),
    .ent_rdata (ent_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_d;
  end

  // Next state, counter updates and next registered outputs.
  always_comb begin
    state_d      = state;
    rows_d       = rows;
    cols_d       = cols;
    vec_cnt_d    = vec_cnt;
    nnz_d        = nnz;
    hdr_seen_d   = hdr_seen;
    vcnt_d       = vcnt;
    ecnt_d       = ecnt;
    gcnt_d       = gcnt;
    err_d        = err;
    busy_d       = busy;
    s_ready_d    = s_ready;
    frame_done_d = 1'b0;
    tx_valid_d   = 1'b0;
    tx_val_d     = '0;
    tx_ipv_d     = 1'b0;
    vec_we       = 1'b0;
    ent_we       = 1'b0;
    unique case (state)
      LOAD: begin
        s_ready_d = 1'b1;
        busy_d    = 1'b0;
        if (hs) begin
          unique case (s_kind)
            KIND_HDR: begin
              rows_d     = hdr_rows;
              cols_d     = hdr_cols;
              vec_cnt_d  = '0;
              nnz_d      = '0;
              err_d      = hdr_bad;
              hdr_seen_d = !hdr_bad;
            end
            KIND_VEC: begin
              if (!hdr_seen || vec_cnt == cols) begin
                err_d = 1'b1;
              end else begin
                vec_we    = 1'b1;
                vec_cnt_d = vec_cnt + DIM_W'(1);
              end
            end
            KIND_ENT: begin
              if (!hdr_seen || nnz == MAX_NNZ_V) begin
                err_d = 1'b1;
              end else begin
                ent_we = 1'b1;
                nnz_d  = nnz + NW'(1);
              end
`ifdef STREAM_TX_COLCHK_EN
              if (hdr_seen && ent_in.col >= cols)
                err_d = 1'b1;
`endif
            end
            KIND_END: begin
              if (!hdr_seen) begin
                err_d = 1'b1;
              end else begin
                if (vec_cnt < cols) err_d = 1'b1;
                state_d   = TX_ROWS;
                s_ready_d = 1'b0;
                busy_d    = 1'b1;
              end
            end
          endcase
        end
      end
      TX_ROWS: begin
        tx_valid_d           = 1'b1;
        {tx_val_d, tx_ipv_d} = rows;
        state_d              = TX_COLS;
      end
      TX_COLS: begin
        tx_valid_d           = 1'b1;
        {tx_val_d, tx_ipv_d} = cols;
        vcnt_d               = '0;
        state_d              = TX_VEC;
      end
      TX_VEC: begin
        tx_valid_d = 1'b1;
        tx_val_d   = vec_rdata;
        vcnt_d     = vcnt + DIM_W'(1);
        if (vcnt == cols - DIM_W'(1)) begin
          vcnt_d  = '0;
          ecnt_d  = '0;
          gcnt_d  = '0;
          state_d = (nnz == '0) ? GAP : TX_VAL;
        end
      end
      TX_VAL: begin
        tx_valid_d = 1'b1;
        tx_val_d   = ent_rdata.val;
        tx_ipv_d   = ent_rdata.last;
        state_d    = TX_IDX;
      end
      TX_IDX: begin
        tx_valid_d           = 1'b1;
        {tx_val_d, tx_ipv_d} = ent_rdata.col;
        if (ecnt == pad_nnz - NW'(1)) begin
          ecnt_d  = '0;
          gcnt_d  = '0;
          state_d = GAP;
        end else begin
          ecnt_d  = ecnt + NW'(1);
          state_d = TX_VAL;
        end
      end
      GAP: begin
        gcnt_d = gcnt + GW'(1);
        if (gcnt == GAP_LAST) begin
          frame_done_d = 1'b1;
          gcnt_d       = '0;
          vec_cnt_d    = '0;
          nnz_d        = '0;
          vcnt_d       = '0;
          ecnt_d       = '0;
          hdr_seen_d   = 1'b0;
          state_d      = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Counters, header fields and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows       <= '0;
      cols       <= '0;
      vec_cnt    <= '0;
      nnz        <= '0;
      hdr_seen   <= 1'b0;
      vcnt       <= '0;
      ecnt       <= '0;
      gcnt       <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      s_ready    <= 1'b1;
      frame_done <= 1'b0;
      tx_valid   <= 1'b0;
      tx_val     <= '0;
      tx_ipv     <= 1'b0;
    end else begin
      rows       <= rows_d;
      cols       <= cols_d;
      vec_cnt    <= vec_cnt_d;
      nnz        <= nnz_d;
      hdr_seen   <= hdr_seen_d;
      vcnt       <= vcnt_d;
      ecnt       <= ecnt_d;
      gcnt       <= gcnt_d;
      err        <= err_d;
      busy       <= busy_d;
      s_ready    <= s_ready_d;
      frame_done <= frame_done_d;
      tx_valid   <= tx_valid_d;
      tx_val     <= tx_val_d;
      tx_ipv     <= tx_ipv_d;
    end
  end

endmodule

// File: tb/tb_smvm_stream_tx.sv
// Bench for smvm_stream_tx: scoreboard of expected stream pairs.
// Honours STREAM_TX_COLCHK_EN for the column-range case.
module tb_smvm_stream_tx;
  import smvm_stream_pkg::*;

  localparam int GAP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [1:0]  s_kind = 2'd0;
  logic [17:0] s_data = '0;
  logic [7:0]  tx_val;
  logic        tx_ipv;
  logic        tx_valid;
  logic        busy;
  logic        err;
  logic        frame_done;

  smvm_stream_tx dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_kind     (s_kind),
    .s_data     (s_data),
    .tx_val     (tx_val),
    .tx_ipv     (tx_ipv),
    .tx_valid   (tx_valid),
    .busy       (busy),
    .err        (err),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;
  int cyc = 0;
  int txn = 0;
  int first_tx = 0;
  int last_tx = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  int end_cyc = 0;
  logic [8:0] exp_q[$];

`ifdef STREAM_TX_COLCHK_EN
  localparam int COLCHK = 1;
`else
  localparam int COLCHK = 0;
`endif

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got == exp) npass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid) begin
        if (exp_q.size() == 0) begin
          chk("tx:extra", 1, 0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("tx:pair", int'({tx_val, tx_ipv}), int'(e));
        end
        if (txn == 0) first_tx = cyc;
        last_tx = cyc;
        txn++;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
  end

  function automatic logic [17:0] ent_w(input int v, input int c,
                                        input bit l);
    return {l, c[8:0], v[7:0]};
  endfunction

  task automatic model(input int r, input int c, input int vec[$],
                       input logic [17:0] ents[$], output int n);
    int nz, p, v;
    logic [17:0] w;
    exp_q.push_back(r[8:0]);
    exp_q.push_back(c[8:0]);
    for (int i = 0; i < c; i++) begin
      v = (i < vec.size()) ? vec[i] : 0;
      exp_q.push_back({v[7:0], 1'b0});
    end
    nz = (ents.size() > 64) ? 64 : ents.size();
    p = (nz + 3) / 4 * 4;
    for (int e = 0; e < p; e++) begin
      w = (e < nz) ? ents[e] : 18'd0;
      exp_q.push_back({w[7:0], w[17]});
      exp_q.push_back(w[16:8]);
    end
    n = 2 + c + 2 * p;
  endtask

  task automatic send(input logic [1:0] k, input logic [17:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_kind = k;
    s_data = d;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 1000);
    chk("send:timeout", int'(s_ready), 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int n);
    int k = 0;
    int base;
    base = fd_cnt;
    while (fd_cnt == base && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({tag, ":timeout"}, int'(k < 2000), 1);
    chk({tag, ":ntx"}, txn, n);
    chk({tag, ":span"}, last_tx - first_tx + 1, n);
    chk({tag, ":lat"}, first_tx - end_cyc, 1);
    chk({tag, ":gap"}, fd_cyc - last_tx, GAP);
    chk({tag, ":q"}, exp_q.size(), 0);
    @(negedge clk);
    #1;
    chk({tag, ":rdy"}, int'(s_ready), 1);
    chk({tag, ":busy0"}, int'(busy), 0);
  endtask

  task automatic load_frame(input int r, input int c, input int vec[$],
                            input logic [17:0] ents[$], output int n);
    int v;
    model(r, c, vec, ents, n);
    txn = 0;
    send(KIND_HDR, {r[8:0], c[8:0]});
    foreach (vec[i]) begin
      v = vec[i];
      send(KIND_VEC, {10'd0, v[7:0]});
    end
    foreach (ents[i]) send(KIND_ENT, ents[i]);
    send(KIND_END, 18'd0);
    end_cyc = cyc;
  endtask

  task automatic do_frame(input string tag, input int r, input int c,
                          input int vec[$], input logic [17:0] ents[$],
                          input int exp_err);
    int n;
    load_frame(r, c, vec, ents, n);
    chk({tag, ":err"}, int'(err), exp_err);
    chk({tag, ":busy"}, int'(busy), 1);
    wait_frame(tag, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vq[$];
    logic [17:0] eq[$];
    int n, k;

    repeat (3) @(negedge clk);
    chk("rst:ready", int'(s_ready), 1);
    chk("rst:valid", int'(tx_valid), 0);
    chk("rst:pair", int'({tx_val, tx_ipv}), 0);
    chk("rst:busy", int'(busy), 0);
    chk("rst:err", int'(err), 0);
    chk("rst:done", int'(frame_done), 0);
    rst = 1'b0;
    @(negedge clk);

    vq = '{5, 6, 7};
    eq = '{ent_w(3, 0, 0), ent_w(4, 2, 1), ent_w(9, 1, 1)};
    do_frame("basic", 2, 3, vq, eq, 0);

    vq = '{10, 20};
    eq = {};
    do_frame("nnz0", 1, 2, vq, eq, 0);

    vq = '{8, 9};
    eq = '{ent_w(1, 0, 1)};
    do_frame("short", 1, 4, vq, eq, 1);

    vq = '{1};
    eq = {};
    for (int i = 0; i < 65; i++) eq.push_back(ent_w(i + 1, 0, i[0]));
    do_frame("ovf", 1, 1, vq, eq, 1);

    txn = 0;
    send(KIND_HDR, {9'd1, 9'd0});
    chk("badhdr:err", int'(err), 1);
    send(KIND_END, 18'd0);
    repeat (20) @(negedge clk);
    chk("badhdr:ntx", txn, 0);
    chk("badhdr:rdy", int'(s_ready), 1);
    chk("badhdr:busy", int'(busy), 0);
    send(KIND_HDR, {9'd1, 9'd2});
    chk("badhdr:clr", int'(err), 0);
    send(KIND_HDR, {9'd1, 9'd257});
    chk("bigcols:err", int'(err), 1);

    vq = '{1, 2, 3};
    eq = '{ent_w(7, 5, 1)};
    do_frame("colchk", 1, 3, vq, eq, COLCHK);

    vq = '{8, 9};
    eq = {};
    load_frame(1, 8, vq, eq, n);
    k = 0;
    while (txn < 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid:reach", int'(txn >= 4), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid:valid", int'(tx_valid), 0);
    chk("rstmid:rdy", int'(s_ready), 1);
    chk("rstmid:err", int'(err), 0);
    chk("rstmid:busy", int'(busy), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    vq = '{5, 6, 7};
    eq = '{ent_w(3, 0, 0), ent_w(4, 2, 1), ent_w(9, 1, 1)};
    do_frame("again", 2, 3, vq, eq, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
